// File: rtl/uart_tx_port_pkg.sv
// ============================================================================
// Module   : uart_defs (package)
// Purpose  : Shared definitions for the uart_tx_port transmitter: FSM state
//            encoding, status register bit positions and the default bit
//            period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_defs;

  // Transmit FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Status register bit positions.
  localparam int c_ST_BUSY = 0;
  localparam int c_ST_FULL = 1;
  localparam int c_ST_OVF  = 2;

  // 115200 baud at 12 MHz.
  localparam int c_DEFAULT_CLK_DIV = 104;

endpackage

`default_nettype wire

// File: rtl/uart_tx_port_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO. A push while full is dropped; a
//            pop in the same cycle does not make room for it.
// Ports    : clk, reset (sync, active-high), push, pop, din -> dout (head
//            entry, valid while !empty), full, empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // Fullness is judged before the edge, so a simultaneous pop never frees a slot.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_port.sv
// ============================================================================
// Module   : uart_tx_port
// Purpose  : Memory-mapped 8N1 UART transmitter. Bytes written to ADDR are
//            queued in a FIFO and shifted out LSB-first on txd. STAT_ADDR
//            reads {29'b0, overflow, full, busy}; writing bit 2 there clears
//            the sticky overflow flag.
// Ports    : clk, reset (sync, active-high), addr/wdata/wen (bus write),
//            rdata (combinational status read), txd (serial out, idles
//            high), busy (frame in progress or FIFO non-empty).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_port
  import uart_defs::*;
#(
  parameter logic [31:0] ADDR       = 32'h0000_0000,
  parameter logic [31:0] STAT_ADDR  = 32'h0000_0004,
  parameter int          CLK_DIV    = c_DEFAULT_CLK_DIV,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy
);

  localparam int             CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  c_CNT_LOAD = CW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          ovf_q, ovf_d;

  logic          push_req;
  logic          stat_wr;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          unused_wdata;

  assign push_req     = wen && (addr == ADDR);
  assign stat_wr      = wen && (addr == STAT_ADDR);
  assign unused_wdata = ^wdata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow: a dropped write wins over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr && wdata[c_ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    txd      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          cnt_d    = c_CNT_LOAD;
          state_d  = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (cnt_q == '0) begin
          cnt_d    = c_CNT_LOAD;
          bitidx_d = 3'd0;
          state_d  = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        txd = shreg_q[0];
        if (cnt_q == '0) begin
          cnt_d   = c_CNT_LOAD;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitidx_d = bitidx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            cnt_d    = c_CNT_LOAD;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    rdata = '0;
    if (addr == STAT_ADDR) begin
      rdata[c_ST_BUSY] = busy;
      rdata[c_ST_FULL] = fifo_full;
      rdata[c_ST_OVF]  = ovf_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_port.sv
// ============================================================================
// Module   : tb_uart_tx_port
// Purpose  : Self-checking bench for uart_tx_port. A queue-based model of
//            the transmitter predicts txd, busy and the status read each
//            cycle from frame position arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_port;

  localparam int          CD     = 4;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] A_DATA = 32'h0000_0100;
  localparam logic [31:0] A_STAT = 32'h0000_0104;
  localparam logic [31:0] A_OTHR = 32'h0000_0200;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] rdata;
  logic        txd;
  logic        busy;

  int n_vec;
  int n_err;

  // Reference model state.
  byte unsigned mq[$];
  bit           m_active;
  int           m_pos;
  logic [7:0]   m_cur;
  bit           m_ovf;

  uart_tx_port #(
    .ADDR       (A_DATA),
    .STAT_ADDR  (A_STAT),
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .wen   (wen),
    .rdata (rdata),
    .txd   (txd),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CD;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic exp_busy();
    return m_active || (mq.size() != 0);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a != A_STAT) return 32'h0;
    return {29'b0, m_ovf, (mq.size() == DEPTH), exp_busy()};
  endfunction

  // One clock edge of the model: frame timing by elapsed cycles, FIFO as a queue.
  task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit full_b;
    if (r) begin
      mq.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
    end else begin
      full_b = (mq.size() == DEPTH);
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * CD) begin
          if (mq.size() != 0) begin
            m_cur = mq.pop_front();
            m_pos = 0;
          end else begin
            m_active = 0;
          end
        end
      end else if (mq.size() != 0) begin
        m_cur    = mq.pop_front();
        m_active = 1;
        m_pos    = 0;
      end
      if (w && a == A_STAT && d[2]) m_ovf = 0;
      if (w && a == A_DATA) begin
        if (full_b) m_ovf = 1;
        else mq.push_back(d[7:0]);
      end
    end
  endtask

  // Apply inputs mid-cycle, check the status read, clock once, check the line.
  task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    reset = r;
    wen   = w;
    addr  = a;
    wdata = d;
    #1;
    check_eq("rdata", rdata, exp_rdata(a));
    @(posedge clk);
    model_step(r, w, a, d);
    @(negedge clk);
    check_eq("txd", {31'b0, txd}, {31'b0, exp_txd()});
    check_eq("busy", {31'b0, busy}, {31'b0, exp_busy()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, ($urandom_range(0, 3) == 0) ? A_OTHR : A_STAT, $urandom);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic [31:0] d;
    d = $urandom;
    d[7:0] = b;
    cycle(1'b0, 1'b1, A_DATA, d);
  endtask

  initial begin
    int k;
    n_vec    = 0;
    n_err    = 0;
    m_active = 0;
    m_pos    = 0;
    m_ovf    = 0;
    m_cur    = 8'h00;
    reset    = 1'b1;
    wen      = 1'b1;
    addr     = A_DATA;
    wdata    = 32'hFF;

    // Reset for two edges with a write pending: it must be ignored.
    repeat (2) @(posedge clk);
    model_step(1'b1, 1'b0, A_STAT, 32'h0);
    @(negedge clk);
    wen   = 1'b0;
    addr  = A_STAT;
    reset = 1'b0;
    #1;
    check_eq("reset_txd", {31'b0, txd}, 32'h1);
    check_eq("reset_busy", {31'b0, busy}, 32'h0);
    check_eq("reset_stat", rdata, 32'h0);

    // Single byte 0xA5.
    write_byte(8'hA5);
    idle(45);

    // Back-to-back frames 0x00, 0xFF.
    write_byte(8'h00);
    write_byte(8'hFF);
    idle(85);

    // Overflow: six writes into a four-entry FIFO, then clear while busy.
    for (int i = 0; i < 6; i++) write_byte(8'(8'h11 * (i + 1)));
    idle(5);
    cycle(1'b0, 1'b1, A_STAT, 32'h4);
    idle(230);

    // Reset during data bit 3 of a 0x55 frame, then a clean 0x33 frame.
    write_byte(8'h55);
    idle(18);
    cycle(1'b1, 1'b0, A_STAT, 32'h0);
    idle(10);
    write_byte(8'h33);
    idle(45);

    // Randomized traffic, including bursts into a full FIFO and stray resets.
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 99);
      if (k < 1)       cycle(1'b1, $urandom_range(0, 1) == 1, A_DATA, $urandom);
      else if (k < 30) cycle(1'b0, 1'b1, A_DATA, $urandom);
      else if (k < 35) cycle(1'b0, 1'b1, A_STAT, $urandom);
      else if (k < 40) cycle(1'b0, 1'b1, A_OTHR, $urandom);
      else             idle(1);
    end
    idle(250);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
